uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/uart_rx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state type and bit-timing derivation.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StStart    = 3'd1,
      StData     = 3'd2,
      StStop     = 3'd3,
      StWaitHigh = 3'd4
   } uart_state_e;

   // Clock cycles per serial bit (integer division).
   function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
      return clk_freq / baud_rate;
   endfunction

   // Offset from the start-bit edge to the middle of the start bit.
   function automatic int unsigned half_bit(input int unsigned cpb);
      return cpb / 2;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; resets to 1 (idle line).
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d_in,
   output logic q_out
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Next-state: shift the input through two stages.
   always_comb begin
      meta_d = d_in;
      sync_d = meta_q;
   end

   // Synchronizer flops, synchronous reset to the idle level.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q_out = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, framing-error detection, break handling.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_RATE = 9600,
   parameter int unsigned CLK_FREQ  = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err,
   output logic       rx_busy
);

   localparam int unsigned ClksPerBit = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int unsigned HalfBit    = half_bit(ClksPerBit);

   if (ClksPerBit < 4 || ClksPerBit > 65535) begin : g_bad_baud
      $fatal(1, "uart_rx: CLK_FREQ/BAUD_RATE must be within 4..65535");
   end

   localparam logic [15:0] BitLast  = 16'(ClksPerBit - 1);
   localparam logic [15:0] HalfLast = 16'(HalfBit - 1);

   logic rxs;

   sync_2ff u_sync (
      .clk   (clk),
      .rst   (rst),
      .d_in  (rx_in),
      .q_out (rxs)
   );

   uart_state_e state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;

   // Next-state and output-pulse logic; pulses default low so they last one cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (!rxs) state_d = StStart;
         end
         StStart: begin
            if (cnt_q == HalfLast) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               // A start bit that is already high again at mid-bit was a glitch.
               state_d   = rxs ? StIdle : StData;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StData: begin
            if (cnt_q == BitLast) begin
               cnt_d            = '0;
               shift_d[bit_idx_q] = rxs;
               if (bit_idx_q == 3'd7) state_d = StStop;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StStop: begin
            if (cnt_q == BitLast) begin
               cnt_d = '0;
               if (rxs) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = StIdle;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = StWaitHigh;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StWaitHigh: begin
            // Hold here through a break so a low line cannot spawn new frames.
            cnt_d = '0;
            if (rxs) state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   assign rx_data      = data_q;
   assign rx_valid     = valid_q;
   assign rx_frame_err = ferr_q;
   assign rx_busy      = (state_q != StIdle);

endmodule
